// File: rtl/fsm_dispatcher.sv
// Instruction dispatcher: decodes one instruction at a time, starts the matching
// sub-FSM, grants it the shared bus and retires it on done or aborts on watchdog.
module fsm_dispatcher (
    input  logic        clock,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic [2:0]  unit_done,
    output logic [2:0]  unit_start,
    output logic [2:0]  bus_grant,
    output logic [3:0]  opcode_out,
    output logic [5:0]  param1_out,
    output logic [5:0]  param2_out,
    output logic        instr_done,
    output logic        illegal,
    output logic        timeout,
    output logic [7:0]  retired_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        RETIRE = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  sel_q, sel_d;
    logic [4:0]  wdog_q, wdog_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [5:0]  param1_q, param1_d;
    logic [5:0]  param2_q, param2_d;
    logic [7:0]  retired_q, retired_d;
    logic        timeout_q, timeout_d;
    logic        instr_ready_q, instr_ready_d;
    logic [2:0]  unit_start_q, unit_start_d;
    logic [2:0]  bus_grant_q, bus_grant_d;
    logic        instr_done_q, instr_done_d;
    logic        illegal_q, illegal_d;
    logic        busy_q, busy_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= 3'd0;
            wdog_q        <= 5'd0;
            opcode_q      <= 4'd0;
            param1_q      <= 6'd0;
            param2_q      <= 6'd0;
            retired_q     <= 8'd0;
            timeout_q     <= 1'b0;
            instr_ready_q <= 1'b1;
            unit_start_q  <= 3'd0;
            bus_grant_q   <= 3'd0;
            instr_done_q  <= 1'b0;
            illegal_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            wdog_q        <= wdog_d;
            opcode_q      <= opcode_d;
            param1_q      <= param1_d;
            param2_q      <= param2_d;
            retired_q     <= retired_d;
            timeout_q     <= timeout_d;
            instr_ready_q <= instr_ready_d;
            unit_start_q  <= unit_start_d;
            bus_grant_q   <= bus_grant_d;
            instr_done_q  <= instr_done_d;
            illegal_q     <= illegal_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        wdog_d    = wdog_q;
        opcode_d  = opcode_q;
        param1_d  = param1_q;
        param2_d  = param2_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    opcode_d = instr[15:12];
                    param1_d = instr[11:6];
                    param2_d = instr[5:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (!opcode_q[3]) begin
                    sel_d   = 3'b001;
                    state_d = START;
                end else if (opcode_q[3:2] == 2'b10) begin
                    sel_d   = 3'b010;
                    state_d = START;
                end else if (opcode_q[3:1] == 3'b110) begin
                    sel_d   = 3'b100;
                    state_d = START;
                end else if (opcode_q == 4'b1110) begin
                    sel_d   = 3'b000;
                    state_d = RETIRE;
                end else begin
                    sel_d   = 3'b000;
                    state_d = ERR;
                end
            end
            START: begin
                wdog_d  = 5'd0;
                state_d = WAIT;
            end
            // Done from the selected unit wins over a watchdog expiry in the same cycle.
            WAIT: begin
                if ((unit_done & sel_q) != 3'd0) begin
                    state_d = RETIRE;
                end else if (wdog_q == 5'd31) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + 5'd1;
                end
            end
            RETIRE:  state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so each register lines up with its state.
    always_comb begin
        instr_ready_d = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        unit_start_d  = (state_d == START) ? sel_d : 3'd0;
        bus_grant_d   = (state_d == START || state_d == WAIT) ? sel_d : 3'd0;
        instr_done_d  = (state_d == RETIRE);
        illegal_d     = (state_d == ERR);
        retired_d     = retired_q + {7'd0, (state_d == RETIRE)};
    end

    assign instr_ready   = instr_ready_q;
    assign unit_start    = unit_start_q;
    assign bus_grant     = bus_grant_q;
    assign opcode_out    = opcode_q;
    assign param1_out    = param1_q;
    assign param2_out    = param2_q;
    assign instr_done    = instr_done_q;
    assign illegal       = illegal_q;
    assign timeout       = timeout_q;
    assign retired_count = retired_q;
    assign busy          = busy_q;

endmodule

// File: doc/fsm_dispatcher.md
FSM_DISPATCHER -- requirements
Module: fsm_dispatcher

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port: instr_valid  input  1  instruction word present on instr.
REQ-004 SHALL have port: instr  input  16  opcode [15:12], param1 [11:6], param2/immediate [5:0].
REQ-005 SHALL have port: instr_ready  output  1  dispatcher can accept an instruction.
REQ-006 SHALL have port: unit_done  input  3  done pulses from the three sub-FSMs: [0] register ALU, [1] immediate ALU, [2] memory.
REQ-007 SHALL have port: unit_start  output  3  one-hot start pulse to the selected sub-FSM.
REQ-008 SHALL have port: bus_grant  output  3  one-hot shared-bus ownership for the selected sub-FSM.
REQ-009 SHALL have port: opcode_out  output  4  latched opcode, driven to the sub-FSMs.
REQ-010 SHALL have port: param1_out  output  6  latched param1.
REQ-011 SHALL have port: param2_out  output  6  latched param2/immediate.
REQ-012 SHALL have port: instr_done  output  1  one-cycle retire pulse.
REQ-013 SHALL have port: illegal  output  1  one-cycle pulse on an illegal opcode.
REQ-014 SHALL have port: timeout  output  1  one-cycle pulse on a watchdog abort.
REQ-015 SHALL have port: retired_count  output  8  count of retired instructions.
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, DECODE, START, WAIT, RETIRE, ERR.
REQ-018 SHALL drive every output from a register; no combinational input-to-output path.
REQ-019 SHALL hold instr_ready=1 only in IDLE.
REQ-020 SHALL, in IDLE with instr_valid=1: latch instr fields into opcode_out/param1_out/param2_out; next state DECODE.
REQ-021 SHALL decode opcode in DECODE, one cycle:
- 0000-0111 -> unit 0
- 1000-1011 -> unit 1
- 1100-1101 -> unit 2
- 1110 (NOP) -> RETIRE, no start pulse
- 1111 -> ERR
REQ-022 SHALL, in START, assert unit_start[sel]=1 for exactly one cycle, assert bus_grant[sel], then go to WAIT.
REQ-023 SHALL hold bus_grant[sel] from START through the last WAIT cycle; bus_grant is 0 in all other states.
REQ-024 SHALL ignore unit_done in all states except WAIT, and ignore unit_done bits of non-selected units.
REQ-025 SHALL, in WAIT with unit_done[sel]=1, go to RETIRE.
REQ-026 SHALL, in RETIRE, pulse instr_done for one cycle, increment retired_count (wraps 255->0), then go to IDLE.
REQ-027 SHALL keep a 5-bit watchdog, cleared on entry to WAIT and incremented each WAIT cycle without done.
- On the 32nd WAIT cycle without done: pulse timeout, drop bus_grant, go to IDLE, no increment.
REQ-028 SHALL treat done and watchdog expiry in the same cycle as done, i.e. retire.
REQ-029 SHALL, in ERR, pulse illegal for one cycle, not count the instruction, then go to IDLE.
REQ-030 SHALL meet this latency: accept edge T; start high in cycle T+2; done seen at W -> instr_done at W+1; instr_ready at W+2.
REQ-031 SHALL hold latched fields stable from DECODE until the return to IDLE; instr changes in that interval are ignored.

Reset
REQ-032 SHALL, while reset=1 on a clock edge, enter IDLE and clear all outputs, latches and counters to 0, except instr_ready=1.
REQ-033 SHALL, on reset mid-operation, drop unit_start/bus_grant the next cycle and discard the in-flight instruction.

Verification
REQ-034 Register ALU op: instr=0x1042 -> unit_start=001 at T+2; done[0] after 5 cycles -> instr_done=1, retired_count=1, opcode_out=1, param1_out=1, param2_out=2.
REQ-035 Immediate op: instr=0x9FC5 -> unit_start=010, bus_grant=010 until done[1]; stray done[0] during WAIT is ignored.
REQ-036 NOP and illegal ops: 0xE000 -> instr_done with no start pulse; 0xF000 -> illegal pulse, retired_count unchanged.
REQ-037 Watchdog: opcode 1100, no done -> timeout pulse exactly 32 WAIT cycles after entry, bus_grant=000, back to IDLE.
REQ-038 Counter wrap and reset: 256 NOP retires -> retired_count=0; reset asserted during WAIT -> all outputs 0 except instr_ready=1 on the next cycle.
